mdu_unit: RTL and testbench
===========================

# mdu_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, in the E stage beside the ALU. It takes start, op, read-select and forwarded operands from the E pipeline register, and returns `mdu_result` for capture into the M pipeline register. It raises `busy` so D-stage hazard logic can stall HI/LO-dependent instructions. Multiply and divide run as counted iterations, and HI/LO are committed only on the final cycle.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult/multu (and madd family); legal range 1–15.
- `DIV_CYCLES`, 10: busy cycles for div/divu; legal range 1–15.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-low: 0 resets immediately, release is synchronised externally.
- `start`  in  1  launch op this cycle (StartE).
- `op`  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7–10 see Configuration; others none.
- `read_hilo`  in  2  0 none, 1 HI, 2 LO, 3 none.
- `a`  in  32  rs operand, forwarded.
- `b`  in  32  rt operand, forwarded.
- `busy`  out  1  operation in flight.
- `mdu_result`  out  32  selected HI/LO, combinational.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States:
  - IDLE: `busy` = 0.
  - RUN: `busy` = 1; a 4-bit down-counter `cnt` and a 64-bit pending result {`p_hi`,`p_lo`} are held.
- IDLE, `start` = 1, op 1–4: compute the pending result from `a`/`b` at that edge, load `cnt` = MULT_CYCLES or DIV_CYCLES, go to RUN.
- RUN: `cnt` decrements each edge. On the edge where `cnt` = 1, write {`hi`,`lo`} ← pending and go to IDLE.
- mult: signed 32×32→64, HI = upper word, LO = lower word. multu: unsigned.
- div: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. divu: unsigned.
- Divide by zero: the unit still runs DIV_CYCLES busy cycles; HI and LO stay unchanged.
- div 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- mthi/mtlo: `start` = 1 in IDLE writes `a` into HI or LO at that edge. No busy cycles; the unit stays IDLE.
- `start` while RUN is ignored (hazard logic guarantees it does not occur). `start` with op 0 or an undefined op is a no-op.
- `mdu_result` = HI for `read_hilo` 1, LO for 2, otherwise 0. It always reads the committed registers and never the pending result.
- Reset (async, even mid-RUN): state IDLE, `cnt` 0, `hi`/`lo`/pending 0, `busy` 0, `mdu_result` 0. An in-flight op is discarded.

## Timing
- Start sampled at edge T. `busy` is high for cycles T+1 … T+N (N = configured cycles).
- HI/LO update at edge T+N. New values are visible on `hi`/`lo`/`mdu_result` in cycle T+N+1, the first cycle with `busy` = 0.
- A new `start` is accepted in cycle T+N+1 (back-to-back, no idle gap).
- mthi/mtlo at edge T → visible in cycle T+1.
- D-stage stalls on (`start` | `busy`) for HI/LO reads and MDU ops. This unit exports only `busy`.

## Configuration
- `MDU_MADD_EN` defined: ops 7 madd, 8 maddu, 9 msub, 10 msubu are enabled.
  - {HI,LO} ± product, with a signed or unsigned product respectively.
  - The accumulate uses {HI,LO} sampled at start, wraps modulo 2^64, and takes MULT_CYCLES.
- Undefined: ops 7–10 behave as no-ops, and no accumulate adder is synthesised.

## Test plan
- Reset, then mult a = 0xFFFFFFFE (-2), b = 3 → `busy` high exactly 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA; `mdu_result` = LO with `read_hilo` = 2.
- div a = 0xFFFFFFF9 (-7), b = 2 → after 10 busy cycles LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Then divu of the same operands → LO = 0x7FFFFFFC, HI = 1.
- mthi 0x12345678 then div by zero → `busy` high 10 cycles; HI stays 0x12345678 and LO is unchanged.
- multu 0xFFFFFFFF × 0xFFFFFFFF, then `start` asserted again mid-RUN → second start ignored; HI = 0xFFFFFFFE, LO = 1. Back-to-back multu in the first idle cycle is accepted.
- Start div, assert `rst` = 0 asynchronously at busy cycle 4 → `busy`, `hi`, `lo` are 0 immediately; no commit after release.
- With `MDU_MADD_EN`: HI = 0, LO = 0xFFFFFFFF, then maddu 1 × 1 → HI = 1, LO = 0.

Source files
------------

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 7-10).
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [1:0]  read_hilo,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] mdu_result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic        skip_q, skip_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Signed divide via magnitudes; a zero divisor is
  // replaced by 1 so the datapath never sees x/0.
  logic        b_zero;
  logic [31:0] ua, ub, ub_nz, sq, sr;
  logic [31:0] q_s, r_s;
  logic [31:0] bu_nz, q_u, r_u;
  assign b_zero = (b == 32'd0);
  assign ua     = a[31] ? -a : a;
  assign ub     = b[31] ? -b : b;
  assign ub_nz  = b_zero ? 32'd1 : ub;
  assign sq     = ua / ub_nz;
  assign sr     = ua % ub_nz;
  assign q_s    = (a[31] ^ b[31]) ? -sq : sq;
  assign r_s    = a[31] ? -sr : sr;
  assign bu_nz  = b_zero ? 32'd1 : b;
  assign q_u    = a / bu_nz;
  assign r_u    = a % bu_nz;

  logic is_mult, is_multu, is_div, is_divu;
  logic is_mthi, is_mtlo;
  assign is_mult  = (op == OP_MULT);
  assign is_multu = (op == OP_MULTU);
  assign is_div   = (op == OP_DIV);
  assign is_divu  = (op == OP_DIVU);
  assign is_mthi  = (op == OP_MTHI);
  assign is_mtlo  = (op == OP_MTLO);

`ifdef MDU_MADD_EN
  logic is_madd, is_maddu, is_msub, is_msubu;
  assign is_madd  = (op == OP_MADD);
  assign is_maddu = (op == OP_MADDU);
  assign is_msub  = (op == OP_MSUB);
  assign is_msubu = (op == OP_MSUBU);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    skip_d  = skip_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_mult: begin
              {phi_d, plo_d} = prod_s;
              cnt_d   = MC;
              skip_d  = 1'b0;
              state_d = S_RUN;
            end
            is_multu: begin
              {phi_d, plo_d} = prod_u;
              cnt_d   = MC;
              skip_d  = 1'b0;
              state_d = S_RUN;
            end
            is_div: begin
              phi_d   = r_s;
              plo_d   = q_s;
              cnt_d   = DC;
              skip_d  = b_zero;
              state_d = S_RUN;
            end
            is_divu: begin
              phi_d   = r_u;
              plo_d   = q_u;
              cnt_d   = DC;
              skip_d  = b_zero;
              state_d = S_RUN;
            end
            is_mthi: hi_d = a;
            is_mtlo: lo_d = a;
`ifdef MDU_MADD_EN
            is_madd: begin
              {phi_d, plo_d} = {hi_q, lo_q} + prod_s;
              cnt_d   = MC;
              skip_d  = 1'b0;
              state_d = S_RUN;
            end
            is_maddu: begin
              {phi_d, plo_d} = {hi_q, lo_q} + prod_u;
              cnt_d   = MC;
              skip_d  = 1'b0;
              state_d = S_RUN;
            end
            is_msub: begin
              {phi_d, plo_d} = {hi_q, lo_q} - prod_s;
              cnt_d   = MC;
              skip_d  = 1'b0;
              state_d = S_RUN;
            end
            is_msubu: begin
              {phi_d, plo_d} = {hi_q, lo_q} - prod_u;
              cnt_d   = MC;
              skip_d  = 1'b0;
              state_d = S_RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          if (!skip_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      skip_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      skip_q  <= skip_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    mdu_result = 32'd0;
    unique case (read_hilo)
      2'd1:    mdu_result = hi_q;
      2'd2:    mdu_result = lo_q;
      default: mdu_result = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed table-driven bench for mdu_unit.
// Compile with +define+MDU_MADD_EN to also cover ops 7-10.
module tb_mdu_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [1:0]  read_hilo;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] mdu_result;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec;
  int n_miss;

  mdu_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .read_hilo  (read_hilo),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .mdu_result (mdu_result),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_outputs(input string nm, input logic [31:0] eh,
                             input logic [31:0] el);
    chk({nm, ".hi"}, hi, eh);
    chk({nm, ".lo"}, lo, el);
    read_hilo = 2'd1;
    #1 chk({nm, ".rd_hi"}, mdu_result, eh);
    read_hilo = 2'd2;
    #1 chk({nm, ".rd_lo"}, mdu_result, el);
    read_hilo = 2'd3;
    #1 chk({nm, ".rd_none"}, mdu_result, 32'd0);
    read_hilo = 2'd0;
  endtask

  // Called at a negedge; returns in the first idle cycle after the op.
  task automatic apply(input vec_t v);
    int n;
    n_vec++;
    start = 1'b1;
    op    = v.op;
    a     = v.a;
    b     = v.b;
    @(negedge clk);
    start = 1'b0;
    op    = 4'd0;
    n     = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({v.name, ".busy_cycles"}, 32'(n), 32'(v.cyc));
    chk_outputs(v.name, v.hi, v.lo);
  endtask

  initial begin
    vec_t v;
    int   n;
    n_vec     = 0;
    n_miss    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    op        = 4'd0;
    read_hilo = 2'd0;
    a         = 32'd0;
    b         = 32'd0;

    vt[0]  = '{"mult_m2x3", 4'd1, 32'hFFFFFFFE, 32'd3, 5,
               32'hFFFFFFFF, 32'hFFFFFFFA};
    vt[1]  = '{"div_m7_2", 4'd3, 32'hFFFFFFF9, 32'd2, 10,
               32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[2]  = '{"divu_m7_2", 4'd4, 32'hFFFFFFF9, 32'd2, 10,
               32'h00000001, 32'h7FFFFFFC};
    vt[3]  = '{"mthi", 4'd5, 32'h12345678, 32'd0, 0,
               32'h12345678, 32'h7FFFFFFC};
    vt[4]  = '{"div_by0", 4'd3, 32'd5, 32'd0, 10,
               32'h12345678, 32'h7FFFFFFC};
    vt[5]  = '{"mtlo", 4'd6, 32'hCAFEBABE, 32'd7, 0,
               32'h12345678, 32'hCAFEBABE};
    vt[6]  = '{"divu_by0", 4'd4, 32'd1, 32'd0, 10,
               32'h12345678, 32'hCAFEBABE};
    vt[7]  = '{"div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10,
               32'h00000000, 32'h80000000};
    vt[8]  = '{"mult_min", 4'd1, 32'h80000000, 32'h80000000, 5,
               32'h40000000, 32'h00000000};
    vt[9]  = '{"divu_100_7", 4'd4, 32'd100, 32'd7, 10,
               32'h00000002, 32'h0000000E};
    vt[10] = '{"div_13_m4", 4'd3, 32'd13, 32'hFFFFFFFC, 10,
               32'h00000001, 32'hFFFFFFFD};
    vt[11] = '{"div_m13_4", 4'd3, 32'hFFFFFFF3, 32'd4, 10,
               32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[12] = '{"op_none", 4'd0, 32'd9, 32'd9, 0,
               32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[13] = '{"op_undef", 4'd15, 32'd9, 32'd9, 0,
               32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[14] = '{"mult_7_m6", 4'd1, 32'd7, 32'hFFFFFFFA, 5,
               32'hFFFFFFFF, 32'hFFFFFFD6};

    repeat (3) @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk_outputs("reset", 32'd0, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) apply(vt[i]);

    // multu with a second start arriving mid-RUN
    n_vec++;
    start = 1'b1;
    op    = 4'd2;
    a     = 32'hFFFFFFFF;
    b     = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    n     = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 2) begin
        start = 1'b1;
        op    = 4'd1;
        a     = 32'd1;
        b     = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    op    = 4'd0;
    chk("midrun.busy_cycles", 32'(n), 32'd5);
    chk_outputs("midrun", 32'hFFFFFFFE, 32'h00000001);

    v = '{"b2b_multu", 4'd2, 32'd2, 32'd3, 5, 32'd0, 32'd6};
    apply(v);

`ifdef MDU_MADD_EN
    v = '{"madd_mthi", 4'd5, 32'd0, 32'd0, 0,
          32'd0, 32'd6};
    apply(v);
    v = '{"madd_mtlo", 4'd6, 32'hFFFFFFFF, 32'd0, 0,
          32'd0, 32'hFFFFFFFF};
    apply(v);
    v = '{"maddu_1x1", 4'd8, 32'd1, 32'd1, 5,
          32'd1, 32'd0};
    apply(v);
    v = '{"msub_1x1", 4'd9, 32'd1, 32'd1, 5,
          32'd0, 32'hFFFFFFFF};
    apply(v);
    v = '{"madd_m1x2", 4'd7, 32'hFFFFFFFF, 32'd2, 5,
          32'd0, 32'hFFFFFFFD};
    apply(v);
    v = '{"msubu_max", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,
          32'd2, 32'hFFFFFFFC};
    apply(v);
`else
    v = '{"op7_off", 4'd7, 32'd5, 32'd5, 0, 32'd0, 32'd6};
    apply(v);
    v = '{"op10_off", 4'd10, 32'd5, 32'd5, 0, 32'd0, 32'd6};
    apply(v);
`endif

    // async reset in busy cycle 4 of a divide
    n_vec++;
    start = 1'b1;
    op    = 4'd4;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    op    = 4'd0;
    repeat (3) @(negedge clk);
    chk("rstrun.busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstrun.busy", 32'(busy), 32'd0);
    chk_outputs("rstrun", 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("rstrun.busy_after", 32'(busy), 32'd0);
    chk_outputs("rstrun_after", 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
